// File: rtl/bp_pkg.sv
// ----------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the fetch stage and its branch target buffer.
// Default widths for XLEN, BTB depth and direction-counter size, the
// weakly-taken counter value a freshly allocated entry starts at, and the
// packed view of one BTB entry (valid, tag, target, ctr).
// ----------------------------------------------------------------------------
package bp_pkg;

    localparam int XLEN        = 32;
    localparam int BTB_ENTRIES = 16;
    localparam int IDX_W       = $clog2(BTB_ENTRIES);
    localparam int CTR_BITS    = 2;
    localparam int TAG_W       = XLEN - IDX_W - 2;

    // Counter MSB set, all lower bits clear: the smallest value that predicts taken.
    localparam logic [CTR_BITS-1:0] CTR_WEAK_TAKEN = CTR_BITS'(1) << (CTR_BITS - 1);

    typedef struct packed {
        logic                valid;
        logic [TAG_W-1:0]    tag;
        logic [XLEN-1:0]     target;
        logic [CTR_BITS-1:0] ctr;
    } btb_entry_t;

endpackage

// File: rtl/btb_array.sv
// ----------------------------------------------------------------------------
// btb_array
// Direct-mapped branch target buffer with saturating direction counters.
//
// Ports
//   clk, rst        clock, synchronous active-high reset (clears valid + ctr)
//   rd_pc_i         lookup PC (fetch stage)
//   rd_hit_o        entry valid and tag matches
//   rd_taken_o      hit and counter MSB set
//   rd_target_o     stored target of the indexed entry
//   wr_en_i         update request (resolved non-JALR control transfer)
//   wr_pc_i         PC of the resolving instruction
//   wr_taken_i      actual direction
//   wr_target_i     actual taken target
//
// The read port is purely combinational on the stored arrays, so a lookup in
// the same cycle as an update to the same entry sees the pre-write contents.
// ----------------------------------------------------------------------------
module btb_array #(
    parameter int XLEN        = bp_pkg::XLEN,
    parameter int BTB_ENTRIES = bp_pkg::BTB_ENTRIES,
    parameter int CTR_BITS    = bp_pkg::CTR_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] rd_pc_i,
    output logic            rd_hit_o,
    output logic            rd_taken_o,
    output logic [XLEN-1:0] rd_target_o,
    input  logic            wr_en_i,
    input  logic [XLEN-1:0] wr_pc_i,
    input  logic            wr_taken_i,
    input  logic [XLEN-1:0] wr_target_i
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [CTR_BITS-1:0]    ctr_q    [BTB_ENTRIES];
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]        target_q [BTB_ENTRIES];

    // ---------------- read port ----------------
    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;

    assign rd_idx      = rd_pc_i[IDX_W+1:2];
    assign rd_tag      = rd_pc_i[XLEN-1:IDX_W+2];
    assign rd_hit_o    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_taken_o  = rd_hit_o && ctr_q[rd_idx][CTR_BITS-1];
    assign rd_target_o = target_q[rd_idx];

    // ---------------- update port ----------------
    logic [IDX_W-1:0]    wr_idx;
    logic [TAG_W-1:0]    wr_tag;
    logic                wr_hit;
    logic                wr_commit;
    logic [CTR_BITS-1:0] ctr_d;

    assign wr_idx = wr_pc_i[IDX_W+1:2];
    assign wr_tag = wr_pc_i[XLEN-1:IDX_W+2];
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    // A miss that was not taken leaves the entry alone; everything else writes.
    assign wr_commit = wr_en_i && (wr_hit || wr_taken_i);

    always_comb begin
        // NOTE: default first so every path assigns ctr_d and no latch is inferred.
        ctr_d = ctr_q[wr_idx];
        if (wr_hit) begin
            if (wr_taken_i) begin
                if (ctr_q[wr_idx] != CTR_MAX) ctr_d = ctr_q[wr_idx] + CTR_BITS'(1);
            end else begin
                if (ctr_q[wr_idx] != '0)      ctr_d = ctr_q[wr_idx] - CTR_BITS'(1);
            end
        end else begin
            ctr_d = CTR_WEAK;
        end
    end

    // NOTE: non-blocking assignments for all sequential state, so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) ctr_q[i] <= '0;
        end else if (wr_commit) begin
            valid_q[wr_idx] <= 1'b1;
            ctr_q[wr_idx]   <= ctr_d;
        end
    end

    // NOTE: tag and target are not reset; they are meaningless while valid is 0,
    // and leaving them out of reset lets them map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            tag_q[wr_idx] <= wr_tag;
            if (wr_taken_i) target_q[wr_idx] <= wr_target_i;
        end
    end

    // Byte-offset bits never participate in index or tag.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

endmodule

// File: rtl/bp_fetch_unit.sv
// ----------------------------------------------------------------------------
// bp_fetch_unit
// Fetch stage of the five-stage RISC-V pipeline: PC register, next-PC
// selection from a BTB prediction, mispredict detection/redirect for the
// instruction resolving in E, and branch / mispredict event counters.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   StallF                      hold the PC
//   PCF, PCPlus4F               fetch PC and PC+4
//   PredTakenF, PredTargetF     F-stage prediction (carried to E)
//   ResolveE, PCE, TakenE,      resolving control transfer in E
//   TargetE, IsJalrE
//   PredTakenE, PredTargetE     prediction that was made for it in F
//   MispredictE                 redirect request (drives FlushD/FlushE)
//   BranchCount, MispredCount   event counters, wrap modulo 2^32
// ----------------------------------------------------------------------------
module bp_fetch_unit #(
    parameter int              XLEN        = bp_pkg::XLEN,
    parameter int              BTB_ENTRIES = bp_pkg::BTB_ENTRIES,
    parameter int              CTR_BITS    = bp_pkg::CTR_BITS,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallF,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] PCPlus4F,
    output logic            PredTakenF,
    output logic [XLEN-1:0] PredTargetF,
    input  logic            ResolveE,
    input  logic [XLEN-1:0] PCE,
    input  logic            TakenE,
    input  logic [XLEN-1:0] TargetE,
    input  logic            IsJalrE,
    input  logic            PredTakenE,
    input  logic [XLEN-1:0] PredTargetE,
    output logic            MispredictE,
    output logic [31:0]     BranchCount,
    output logic [31:0]     MispredCount
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [31:0]     branch_count_q;
    logic [31:0]     mispred_count_q;

    logic            btb_hit;
    logic            btb_taken;
    logic [XLEN-1:0] btb_target;
    logic            btb_wr_en;
    logic [XLEN-1:0] redirect_pc;

    // ---------------- prediction ----------------
    assign PCF         = pc_q;
    assign PCPlus4F    = pc_q + XLEN'(4);
    assign PredTakenF  = btb_taken;
    assign PredTargetF = btb_taken ? btb_target : PCPlus4F;

    // JALR targets come from a register, so they are never cached; reset
    // suppresses any update that coincides with it.
    assign btb_wr_en = ResolveE && !IsJalrE && !rst;

    btb_array #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES),
        .CTR_BITS    (CTR_BITS)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .rd_pc_i     (pc_q),
        .rd_hit_o    (btb_hit),
        .rd_taken_o  (btb_taken),
        .rd_target_o (btb_target),
        .wr_en_i     (btb_wr_en),
        .wr_pc_i     (PCE),
        .wr_taken_i  (TakenE),
        .wr_target_i (TargetE)
    );

    // ---------------- resolution ----------------
    // A predicted-not-taken target is irrelevant, so the target compare only
    // counts when the instruction was actually taken.
    assign MispredictE = ResolveE &&
                         ((TakenE != PredTakenE) || (TakenE && (TargetE != PredTargetE)));

    assign redirect_pc = TakenE ? TargetE : (PCE + XLEN'(4));

    // Redirect outranks the stall: the wrong-path fetch being held is discarded anyway.
    always_comb begin
        pc_d = PredTargetF;
        if (MispredictE)  pc_d = redirect_pc;
        else if (StallF)  pc_d = pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q            <= RESET_PC;
            branch_count_q  <= '0;
            mispred_count_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (ResolveE)    branch_count_q  <= branch_count_q + 32'd1;
            if (MispredictE) mispred_count_q <= mispred_count_q + 32'd1;
        end
    end

    assign BranchCount  = branch_count_q;
    assign MispredCount = mispred_count_q;

    // The hit flag itself is only of interest for debug visibility.
    logic unused_btb_hit;
    assign unused_btb_hit = btb_hit;

endmodule

// File: tb/tb_bp_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_bp_fetch_unit
// Directed test of bp_fetch_unit with default parameters (XLEN 32, 16 BTB
// entries, 2-bit counters, RESET_PC 0). The bench plays the role of E:
// it drives resolutions directly and steers the fetch PC with JALR redirects.
// ----------------------------------------------------------------------------
module tb_bp_fetch_unit;

    logic        clk;
    logic        rst;
    logic        StallF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        ResolveE;
    logic [31:0] PCE;
    logic        TakenE;
    logic [31:0] TargetE;
    logic        IsJalrE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        MispredictE;
    logic [31:0] BranchCount;
    logic [31:0] MispredCount;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_br  = '0;
    logic [31:0] exp_mp  = '0;

    bp_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .StallF       (StallF),
        .PCF          (PCF),
        .PCPlus4F     (PCPlus4F),
        .PredTakenF   (PredTakenF),
        .PredTargetF  (PredTargetF),
        .ResolveE     (ResolveE),
        .PCE          (PCE),
        .TakenE       (TakenE),
        .TargetE      (TargetE),
        .IsJalrE      (IsJalrE),
        .PredTakenE   (PredTakenE),
        .PredTargetE  (PredTargetE),
        .MispredictE  (MispredictE),
        .BranchCount  (BranchCount),
        .MispredCount (MispredCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called right after a falling edge: present a resolution and check the
    // combinational mispredict flag.
    task automatic drive_resolve(input string tag, input logic [31:0] pc, input logic taken,
                                 input logic [31:0] tgt, input logic jalr, input logic ptaken,
                                 input logic [31:0] ptgt, input logic exp_mispred);
        ResolveE    = 1'b1;
        PCE         = pc;
        TakenE      = taken;
        TargetE     = tgt;
        IsJalrE     = jalr;
        PredTakenE  = ptaken;
        PredTargetE = ptgt;
        #1;
        check({tag, "_mispred"}, {31'd0, MispredictE}, {31'd0, exp_mispred});
        exp_br = exp_br + 32'd1;
        if (exp_mispred) exp_mp = exp_mp + 32'd1;
    endtask

    // Let the resolving edge pass, withdraw the resolution, check redirect and counters.
    task automatic finish_resolve(input string tag, input logic [31:0] pc, input logic taken,
                                  input logic [31:0] tgt, input logic exp_mispred);
        @(negedge clk);
        ResolveE   = 1'b0;
        TakenE     = 1'b0;
        IsJalrE    = 1'b0;
        PredTakenE = 1'b0;
        if (exp_mispred) check({tag, "_redirect"}, PCF, taken ? tgt : pc + 32'd4);
        check({tag, "_brcnt"}, BranchCount, exp_br);
        check({tag, "_mpcnt"}, MispredCount, exp_mp);
    endtask

    task automatic resolve(input string tag, input logic [31:0] pc, input logic taken,
                           input logic [31:0] tgt, input logic jalr, input logic ptaken,
                           input logic [31:0] ptgt, input logic exp_mispred);
        drive_resolve(tag, pc, taken, tgt, jalr, ptaken, ptgt, exp_mispred);
        finish_resolve(tag, pc, taken, tgt, exp_mispred);
    endtask

    // Move the fetch PC by resolving a mispredicted JALR from far away.
    task automatic steer(input string tag, input logic [31:0] target);
        resolve(tag, 32'h200, 1'b1, target, 1'b1, 1'b0, 32'h204, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; StallF = 1'b0; ResolveE = 1'b0; PCE = '0; TakenE = 1'b0;
        TargetE = '0; IsJalrE = 1'b0; PredTakenE = 1'b0; PredTargetE = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // ---- reset state and sequential fetch ----
        check("rst_pc",      PCF, 32'h0);
        check("rst_pc4",     PCPlus4F, 32'h4);
        check("rst_ptaken",  {31'd0, PredTakenF}, 32'd0);
        check("rst_ptarget", PredTargetF, 32'h4);
        check("rst_brcnt",   BranchCount, 32'd0);
        check("rst_mpcnt",   MispredCount, 32'd0);
        check("rst_valid",   {16'd0, dut.u_btb.valid_q}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("seq_pc%0d", i), PCF, 32'(4 * i));
            check($sformatf("seq_ptaken%0d", i), {31'd0, PredTakenF}, 32'd0);
        end

        // ---- branch at 0x10 taken to 0x40: allocate, then predict ----
        resolve("br1", 32'h10, 1'b1, 32'h40, 1'b0, 1'b0, 32'h14, 1'b1);
        check("br1_ctr", {30'd0, dut.u_btb.ctr_q[4]}, 32'd2);
        steer("st1", 32'h10);
        check("br2_ptaken",  {31'd0, PredTakenF}, 32'd1);
        check("br2_ptarget", PredTargetF, 32'h40);
        resolve("br2", 32'h10, 1'b1, 32'h40, 1'b0, 1'b1, 32'h40, 1'b0);
        check("br2_nobubble", PCF, 32'h40);

        // ---- counter saturation and decay ----
        resolve("sat_t", 32'h10, 1'b1, 32'h40, 1'b0, 1'b1, 32'h40, 1'b0);
        check("sat_ctr3", {30'd0, dut.u_btb.ctr_q[4]}, 32'd3);
        resolve("sat_nt1", 32'h10, 1'b0, 32'h40, 1'b0, 1'b1, 32'h40, 1'b1);
        steer("st2", 32'h10);
        check("sat_nt1_ptaken", {31'd0, PredTakenF}, 32'd1);
        resolve("sat_nt2", 32'h10, 1'b0, 32'h40, 1'b0, 1'b1, 32'h40, 1'b1);
        steer("st3", 32'h10);
        check("sat_nt2_ptaken",  {31'd0, PredTakenF}, 32'd0);
        check("sat_nt2_ptarget", PredTargetF, 32'h14);

        // ---- JALR redirects but is never cached ----
        resolve("jalr", 32'h20, 1'b1, 32'h80, 1'b1, 1'b0, 32'h24, 1'b1);
        steer("st4", 32'h20);
        check("jalr_hit",    {31'd0, dut.u_btb.rd_hit_o}, 32'd0);
        check("jalr_ptaken", {31'd0, PredTakenF}, 32'd0);

        // ---- stall holds; mispredict overrides stall ----
        StallF = 1'b1;
        @(negedge clk);
        check("stall_hold", PCF, 32'h20);
        resolve("stall_mp", 32'h30, 1'b1, 32'h90, 1'b0, 1'b0, 32'h34, 1'b1);
        StallF = 1'b0;
        steer("st5", 32'h30);
        check("same_pre_ptaken", {31'd0, PredTakenF}, 32'd1);

        // ---- update of the entry being fetched: old prediction this cycle ----
        StallF = 1'b1;
        drive_resolve("same", 32'h30, 1'b0, 32'h90, 1'b0, 1'b0, 32'h34, 1'b0);
        check("same_old_ptaken",  {31'd0, PredTakenF}, 32'd1);
        check("same_old_ptarget", PredTargetF, 32'h90);
        finish_resolve("same", 32'h30, 1'b0, 32'h90, 1'b0);
        check("same_hold",        PCF, 32'h30);
        check("same_new_ptaken",  {31'd0, PredTakenF}, 32'd0);
        check("same_new_ptarget", PredTargetF, 32'h34);
        StallF = 1'b0;

        // ---- aliasing: 0x10 and 0x50 share index 4 ----
        resolve("alias50", 32'h50, 1'b1, 32'h60, 1'b0, 1'b0, 32'h54, 1'b1);
        steer("st6", 32'h10);
        check("alias_10_hit", {31'd0, dut.u_btb.rd_hit_o}, 32'd0);
        check("alias_10_ptaken", {31'd0, PredTakenF}, 32'd0);
        steer("st7", 32'h50);
        check("alias_50_ptaken",  {31'd0, PredTakenF}, 32'd1);
        check("alias_50_ptarget", PredTargetF, 32'h60);
        resolve("alias10", 32'h10, 1'b1, 32'h40, 1'b0, 1'b0, 32'h14, 1'b1);
        steer("st8", 32'h50);
        check("alias_50_evicted", {31'd0, dut.u_btb.rd_hit_o}, 32'd0);

        // ---- branch counter wrap ----
        force dut.branch_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.branch_count_q;
        exp_br = 32'hFFFF_FFFF;
        resolve("wrap", 32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 32'h304, 1'b0);

        // ---- reset coinciding with a resolution: reset wins ----
        rst = 1'b1;
        ResolveE = 1'b1; PCE = 32'h70; TakenE = 1'b1; TargetE = 32'hB0;
        IsJalrE = 1'b0; PredTakenE = 1'b0; PredTargetE = 32'h74;
        @(negedge clk);
        rst = 1'b0; ResolveE = 1'b0; TakenE = 1'b0;
        check("rstres_pc",    PCF, 32'h0);
        check("rstres_brcnt", BranchCount, 32'd0);
        check("rstres_mpcnt", MispredCount, 32'd0);
        check("rstres_valid", {16'd0, dut.u_btb.valid_q}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_fetch_unit.md
# bp_fetch_unit

Parametrised fetch stage for the five-stage RISC-V pipeline: owns the PC register, a direct-mapped branch target buffer (BTB) with saturating direction counters, and mispredict recovery. Predicts the next PC in F, so taken branches and JAL cost no bubbles when predicted correctly. Branches still resolve in E; on a mispredict, F is redirected and the hazard logic flushes D and E. Also maintains branch and mispredict event counters.

## Interface
- XLEN, 32, datapath and PC width
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2; IDX_W = log2(BTB_ENTRIES)
- CTR_BITS, 2, direction counter width, ≥1
- RESET_PC, 32'h0, PC loaded on reset

Clocking: one clock; reset is synchronous and active-high.

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- StallF  in  1  hold the PC (from hazard unit)
- PCF  out  XLEN  current fetch PC (instruction memory address)
- PCPlus4F  out  XLEN  PCF+4
- PredTakenF  out  1  F-stage taken prediction; carried to E by the pipeline registers
- PredTargetF  out  XLEN  predicted next PC; carried to E
- ResolveE  in  1  E holds a branch, JAL or JALR
- PCE  in  XLEN  PC of the resolving instruction
- TakenE  in  1  actual direction (1 for jumps)
- TargetE  in  XLEN  actual taken target
- IsJalrE  in  1  resolving instruction is JALR
- PredTakenE, PredTargetE  in  1, XLEN  prediction made for this instruction in F
- MispredictE  out  1  redirect request; drives FlushD and FlushE
- BranchCount  out  32  resolved control-transfer count
- MispredCount  out  32  mispredict count

## Operation
- BTB entry fields: valid, tag = PC[XLEN-1:IDX_W+2], target, ctr.
- Index = PC[IDX_W+1:2]. PC[1:0] is ignored.
- Lookup (combinational on PCF):
  - hit = valid && tag match.
  - PredTakenF = hit && ctr[CTR_BITS-1].
  - PredTargetF = PredTakenF ? target : PCF+4.
- MispredictE = ResolveE && (TakenE != PredTakenE || (TakenE && TargetE != PredTargetE)).
- Next-PC priority, highest first:
  - rst → RESET_PC
  - MispredictE → (TakenE ? TargetE : PCE+4); applies even while StallF is high
  - StallF → hold PCF
  - otherwise → PredTargetF
- BTB update on ResolveE && !IsJalrE, indexed by PCE:
  - Hit: ctr saturating +1 if TakenE, else saturating −1; target ← TargetE when TakenE.
  - Miss and TakenE: allocate/overwrite the entry with valid=1, new tag, target=TargetE, ctr = 2^(CTR_BITS-1) (weakly taken).
  - Miss and not taken: no write.
- JALR is never written to the BTB. It still mispredicts and redirects normally.
- Counters:
  - BranchCount +1 on every ResolveE.
  - MispredCount +1 on every MispredictE.
  - Both wrap modulo 2^32.
- All arithmetic is modulo 2^XLEN; PC+4 wraps silently.

## Timing
- Prediction is zero-latency: PredTakenF/PredTargetF are valid in the same cycle as PCF.
- A BTB write lands at the edge that ends the ResolveE cycle. If the same cycle reads that entry, the lookup returns the pre-write contents.
- Redirect: PCF equals the corrected PC in the cycle after MispredictE. Mispredict penalty is 2 cycles (the D and E contents are flushed).
- Correctly predicted taken branch or JAL: 0 bubbles.
- Reset values:
  - PCF = RESET_PC, PCPlus4F = RESET_PC+4.
  - All valid bits = 0, all ctr = 0, both counters = 0.
  - PredTakenF = 0, PredTargetF = RESET_PC+4.
- MispredictE is purely combinational; it is 0 whenever ResolveE = 0.
- rst asserted together with ResolveE: reset wins; no BTB or counter update occurs.

## Structure
- Shared package `bp_pkg`: btb_entry_t struct (valid, tag, target, ctr) parametrised via the package's XLEN/IDX_W constants, plus the CTR_WEAK_TAKEN constant.
- Sub-module `btb_array`: storage, combinational read port, synchronous update port, and saturating counter logic.
- Top level holds the PC register, next-PC mux, mispredict compare and event counters.

## Test plan
- Reset then 4 unstalled cycles, no ResolveE → PCF = 0, 4, 8, 12; PredTakenF = 0 throughout; counts = 0.
- Branch at 0x10, taken to 0x40, resolved twice →
  - 1st: MispredictE = 1, next PCF = 0x40, entry allocated with ctr = 2.
  - 2nd: PredTakenF = 1 at PCF = 0x10, PredTargetF = 0x40, no mispredict.
  - MispredCount = 1, BranchCount = 2.
- Saturation, same branch → taken ×3 gives ctr = 3; then not-taken ×1 gives ctr = 2, prediction still taken; a second not-taken gives ctr = 1, PredTakenF = 0.
- JALR at 0x20 to 0x80 → MispredictE = 1, PCF = 0x80 next cycle; a later fetch of 0x20 has hit = 0.
- MispredictE with StallF = 1 → redirect still applied. Resolve of an entry in the same cycle it is fetched → old prediction used, new prediction visible next cycle.
- Alias, BTB_ENTRIES = 16 → branch at 0x10 and branch at 0x50 (same index) evict each other; a fetch of 0x10 after the 0x50 allocation misses. Counter wrap: preload BranchCount = 0xFFFFFFFF, one resolve → 0.
